// File: rtl/spi_mnrch_if.sv
// Host-side bus of the SPI monarch: transaction request from the inertial
// interface FSM and the completion/result returned to it.
interface spi_mnrch_if;
    logic        wrt;
    logic [15:0] wt_data;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output wt_data, input done, input rd_data);
    modport slave  (input wrt, input wt_data, output done, output rd_data);
endinterface

// File: rtl/spi_mnrch.sv
// SPI monarch for 16-bit transfers to the inertial sensor serf (SCLK idles high).
// Optional sticky busy-request flag 'err' is built when SPI_MNRCH_ERR_EN is defined.
module spi_mnrch #(
    parameter int unsigned DIV_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    spi_mnrch_if.slave  bus,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
`ifdef SPI_MNRCH_ERR_EN
    ,
    output logic        err
`endif
);

    localparam logic [DIV_W-1:0] LD       = DIV_W'(2**DIV_W - 5);
    localparam logic [DIV_W-1:0] ALL_ONES = '1;
    localparam logic [DIV_W-1:0] PRE_RISE = DIV_W'(2**(DIV_W-1) - 1);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

    typedef enum logic [1:0] {StIdle, StFront, StShift, StBack} state_e;

    state_e           state_q;
    logic [DIV_W-1:0] sclk_div_q;
    logic [15:0]      shft_reg_q;
    logic [3:0]       bit_cnt_q;
    logic             miso_smpl_q;
    logic             ss_n_q;
    logic             done_q;

    assign SCLK        = sclk_div_q[DIV_W-1];
    assign MOSI        = shft_reg_q[15];
    assign SS_n        = ss_n_q;
    assign bus.done    = done_q;
    assign bus.rd_data = shft_reg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sclk_div_q  <= LD;
            shft_reg_q  <= 16'h0000;
            bit_cnt_q   <= 4'd0;
            miso_smpl_q <= 1'b0;
            ss_n_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sclk_div_q <= LD;
                    if (bus.wrt) begin
                        shft_reg_q <= bus.wt_data;
                        bit_cnt_q  <= 4'd0;
                        ss_n_q     <= 1'b0;
                        done_q     <= 1'b0;
                        state_q    <= StFront;
                    end
                end
                StFront: begin
                    // The all-ones cycle ends the porch; its wrap is the first SCLK fall.
                    sclk_div_q <= sclk_div_q + ONE;
                    if (sclk_div_q == ALL_ONES) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (sclk_div_q == PRE_RISE) begin
                        miso_smpl_q <= MISO;
                    end
                    if (sclk_div_q == ALL_ONES) begin
                        shft_reg_q <= {shft_reg_q[14:0], miso_smpl_q};
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            // Reload keeps SCLK high so no 17th fall is produced.
                            sclk_div_q <= LD;
                            state_q    <= StBack;
                        end else begin
                            sclk_div_q <= sclk_div_q + ONE;
                        end
                    end else begin
                        sclk_div_q <= sclk_div_q + ONE;
                    end
                end
                StBack: begin
                    sclk_div_q <= LD;
                    ss_n_q     <= 1'b1;
                    done_q     <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SPI_MNRCH_ERR_EN
    logic err_q;
    assign err = err_q;

    // A request in IDLE is always accepted, so every wrt either clears or sets the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.wrt) begin
            err_q <= (state_q != StIdle);
        end
    end
`endif

endmodule

// File: tb/tb_spi_mnrch.sv
// Bench for spi_mnrch: behavioural serf, table of transfers with a scoreboard
// queue, plus hand-written busy-request and mid-transfer reset sequences.
module tb_spi_mnrch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic MISO;
    logic SS_n, SCLK, MOSI;
`ifdef SPI_MNRCH_ERR_EN
    logic err;
`endif

    spi_mnrch_if bus ();

    spi_mnrch #(.DIV_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .MISO (MISO),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI)
`ifdef SPI_MNRCH_ERR_EN
        ,
        .err  (err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] sb_q[$];

    // Serf model: answers 0xA5 in the first byte, register contents in the second on reads.
    logic [7:0]  regs [128];
    logic        serf_init = 1'b0;
    logic        ss_prev   = 1'b1;
    logic        sclk_prev = 1'b1;
    logic [4:0]  rise_cnt  = 5'd0;
    logic [15:0] rx        = 16'h0000;
    logic [15:0] resp      = 16'hA500;
    logic        miso_r    = 1'b0;

    assign MISO = miso_r;

    always @(negedge clk) begin
        ss_prev   <= SS_n;
        sclk_prev <= SCLK;
        if (!serf_init) begin
            for (int i = 0; i < 128; i++) regs[i] <= 8'h00;
            regs[7'h0F] <= 8'h6A;
            regs[7'h22] <= 8'h3C;
            regs[7'h23] <= 8'h81;
            serf_init   <= 1'b1;
        end
        if (ss_prev && !SS_n) begin
            rise_cnt <= 5'd0;
            rx       <= 16'h0000;
            resp     <= 16'hA500;
            miso_r   <= 1'b1;
        end else if (!SS_n) begin
            if (!sclk_prev && SCLK) begin
                rise_cnt <= rise_cnt + 5'd1;
                rx       <= {rx[14:0], MOSI};
                if (rise_cnt == 5'd7) begin
                    resp[7:0] <= rx[6] ? regs[{rx[5:0], MOSI}] : 8'h00;
                end
                if (rise_cnt == 5'd15 && !rx[14]) begin
                    regs[rx[13:7]] <= {rx[6:0], MOSI};
                end
            end
            if (sclk_prev && !SCLK && rise_cnt != 5'd0) begin
                miso_r <= resp[4'd15 - rise_cnt[3:0]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one transfer starting in the current cycle (cycle 0 = wrt high).
    task automatic do_xfer(input string tag, input logic [15:0] wd, input logic [15:0] exp_rd,
                           input int busy_at, input int rst_at);
        int   cyc = 0;
        int   lows = 0;
        int   falls = 0;
        int   rises = 0;
        int   first_fall = 0;
        logic sclk_p, ss_p, ss_rise_sclk;
        bit   seen = 0;
        logic [15:0] exp_q;
        check($sformatf("%s.ss_idle", tag), SS_n, 1);
        bus.wt_data = wd;
        bus.wrt     = 1'b1;
        if (rst_at == 0) sb_q.push_back(exp_rd);
        sclk_p = SCLK;
        ss_p   = SS_n;
        ss_rise_sclk = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) begin
                bus.wrt = 1'b0;
                check($sformatf("%s.done_clr", tag), bus.done, 0);
                check($sformatf("%s.ss_low", tag), SS_n, 0);
`ifdef SPI_MNRCH_ERR_EN
                check($sformatf("%s.err_clr", tag), err, 0);
`endif
            end
            if (busy_at > 0 && cyc == busy_at) begin
                bus.wt_data = 16'h0D02;
                bus.wrt     = 1'b1;
            end
            if (busy_at > 0 && cyc == busy_at + 1) begin
                bus.wrt = 1'b0;
`ifdef SPI_MNRCH_ERR_EN
                check($sformatf("%s.err_set", tag), err, 1);
`endif
            end
            if (rst_at > 0 && cyc == rst_at) rst = 1'b1;
            if (rst_at > 0 && cyc == rst_at + 1) begin
                rst = 1'b0;
                check($sformatf("%s.rst_ss", tag), SS_n, 1);
                check($sformatf("%s.rst_sclk", tag), SCLK, 1);
                check($sformatf("%s.rst_done", tag), bus.done, 0);
                check($sformatf("%s.rst_rd", tag), bus.rd_data, 0);
                return;
            end
            if (!SS_n) lows++;
            if (sclk_p && !SCLK) begin
                falls++;
                if (first_fall == 0) first_fall = cyc;
            end
            if (!sclk_p && SCLK) rises++;
            if (!ss_p && SS_n) ss_rise_sclk = SCLK;
            sclk_p = SCLK;
            ss_p   = SS_n;
            if (bus.done) seen = 1;
        end
        if (!seen) begin
            check($sformatf("%s.timeout", tag), 0, 1);
            return;
        end
        check($sformatf("%s.latency", tag), cyc, 263);
        check($sformatf("%s.ss_low_len", tag), lows, 262);
        check($sformatf("%s.falls", tag), falls, 16);
        check($sformatf("%s.rises", tag), rises, 16);
        check($sformatf("%s.front_porch", tag), first_fall, 6);
        check($sformatf("%s.ss_rise_sclk", tag), ss_rise_sclk, 1);
        check($sformatf("%s.ss_end", tag), SS_n, 1);
        check($sformatf("%s.mosi_seq", tag), rx, wd);
        check($sformatf("%s.serf_rises", tag), rise_cnt, 16);
        if (sb_q.size() == 0) begin
            check($sformatf("%s.sb_empty", tag), 0, 1);
        end else begin
            exp_q = sb_q.pop_front();
            check($sformatf("%s.rd_data", tag), bus.rd_data, exp_q);
        end
    endtask

    typedef struct {
        logic [15:0] wd;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int toggles;
        logic [19:0] snap;
        vecs[0] = '{wd: 16'h8F00, rd: 16'hA56A};  // WHO_AM_I
        vecs[1] = '{wd: 16'h0D02, rd: 16'hA500};  // enable INT
        vecs[2] = '{wd: 16'h8D00, rd: 16'hA502};  // read back the write
        vecs[3] = '{wd: 16'hA200, rd: 16'hA53C};  // pitch rate low
        vecs[4] = '{wd: 16'hA300, rd: 16'hA581};  // pitch rate high

        bus.wrt     = 1'b0;
        bus.wt_data = 16'h0000;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset.ss", SS_n, 1);
        check("reset.sclk", SCLK, 1);
        check("reset.done", bus.done, 0);
        check("reset.rd", bus.rd_data, 16'h0000);
        check("reset.mosi", MOSI, 0);
`ifdef SPI_MNRCH_ERR_EN
        check("reset.err", err, 0);
`endif
        toggles = 0;
        snap = {SS_n, SCLK, MOSI, bus.done, bus.rd_data};
        repeat (50) begin
            @(posedge clk);
            #1;
            if ({SS_n, SCLK, MOSI, bus.done, bus.rd_data} != snap) toggles++;
        end
        check("reset.quiet", toggles, 0);

        // Consecutive calls start on the cycle done is first seen: back-to-back transfers.
        for (int i = 0; i < 5; i++) begin
            do_xfer($sformatf("vec%0d", i), vecs[i].wd, vecs[i].rd, 0, 0);
            if (!vecs[i].wd[15]) begin
                check($sformatf("vec%0d.serf_reg", i), regs[vecs[i].wd[14:8]], vecs[i].wd[7:0]);
            end
        end
        check("write.int", regs[7'h0D] == 8'h02, 1);

        // Busy request at cycle 100 must not disturb the transfer or start another.
        repeat (3) @(posedge clk);
        #1;
        do_xfer("busy", 16'h8F00, 16'hA56A, 100, 0);
        toggles = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!SS_n) toggles++;
        end
        check("busy.no_second", toggles, 0);
        check("busy.rd_hold", bus.rd_data, 16'hA56A);
`ifdef SPI_MNRCH_ERR_EN
        check("busy.err_sticky", err, 1);
`endif

        // Reset mid-transfer, then a fresh read.
        do_xfer("abort", 16'h8F00, 16'h0000, 0, 120);
        repeat (2) @(posedge clk);
        #1;
        do_xfer("after_abort", 16'h8F00, 16'hA56A, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mnrch.md
Name: spi_mnrch

Overview:
- SPI monarch (initiator) for 16-bit transactions to the inertial sensor serf; the opposite end of the SPI link.
- Generates SS_n, SCLK and MOSI, and captures MISO.
- Sits between the inertial interface state machine, which issues register reads and writes, and the off-chip iNEMO pins.
- SCLK idles high. MOSI changes on SCLK fall; MISO is sampled around SCLK rise.

Parameters:
- DIV_W, 4: width of the SCLK divider. SCLK = clk / 2^DIV_W. Legal range is DIV_W >= 4.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst  input  1  reset, synchronous, active-high.
- wrt  input  1  single-cycle pulse that starts a transaction. Sampled only in IDLE.
- wt_data  input  16  command/data word. Bit 15 = R/Wn (1 = read), bits 14:8 = address, bits 7:0 = write data.
- MISO  input  1  serial data from the serf.
- SS_n  output  1  active-low serf select.
- SCLK  output  1  serial clock.
- MOSI  output  1  serial data to the serf; always shft_reg[15].
- done  output  1  high when a transaction completes; stays high until the next accepted wrt.
- rd_data  output  16  received word (shft_reg). Valid when done=1; the response byte is in bits 7:0.

Behaviour:
- Reset: state=IDLE, SS_n=1, SCLK=1, done=0, shft_reg/rd_data=0, MOSI=0, bit_cnt=0. Divider is loaded with LD = 2^DIV_W-5 (4'b1011 for DIV_W=4). A reset mid-transaction aborts immediately with these values; there is no partial done.
- SCLK = sclk_div[DIV_W-1]. sclk_div increments every clk outside IDLE except where it is reloaded. Reloads hold SCLK high.
- IDLE:
  - sclk_div holds LD.
  - On wrt: shft_reg<=wt_data, bit_cnt<=0, SS_n<=0, done<=0, go to FRONT.
- FRONT (front porch):
  - Count until sclk_div is all-ones. That cycle is the first SCLK fall.
  - No shift occurs on this fall; go to SHIFT.
  - Front porch is 5 clk from the SS_n fall to the first SCLK fall.
- SHIFT:
  - When sclk_div == 2^(DIV_W-1)-1 (the clk before the rise): MISO_smpl<=MISO.
  - When sclk_div is all-ones (the clk before the fall): shft_reg<={shft_reg[14:0],MISO_smpl}, bit_cnt++.
  - On the 16th shift (bit_cnt==15 at all-ones): sclk_div<=LD so no 17th fall occurs, then go to BACK.
- BACK (back porch):
  - Lasts one clk. Then SS_n<=1, done<=1, go to IDLE.
  - SCLK stays high throughout, so SS_n rises with SCLK high.
- Latency (DIV_W=4):
  - wrt sampled at cycle 0; SS_n low from cycle 1.
  - done=1 and SS_n=1 at cycle 263. General formula: 7+16*2^DIV_W.
  - Exactly 16 SCLK falls and 16 rises per transaction.
- wrt outside IDLE is ignored. The in-flight transfer is unaffected.
- wrt in the same cycle that done is set (BACK→IDLE) is ignored. wrt on the cycle after done is accepted.
- Back-to-back transactions leave a minimum SS_n high time of 1 clk.
- rd_data holds its value in IDLE until the next wrt overwrites shft_reg.

Optional Feature:
- Macro SPI_MNRCH_ERR_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - err sets sticky when wrt is asserted while state != IDLE.
  - err clears only when a wrt is accepted in IDLE.
  - The ignored wrt still has no other effect.
- Undefined:
  - No err port exists.
  - Busy wrt is silently ignored.

Test Plan:
- Reset check: rst high for 2 clk, then low → SS_n=1, SCLK=1, done=0, rd_data=16'h0000. Hold for 50 clk; nothing toggles.
- Read WHO_AM_I: wrt with wt_data=16'h8F00 against the serf model → MOSI bit sequence 1000_1111_0000_0000, 16 SCLK rises, done at cycle 263, rd_data[7:0]=8'h6A, SS_n low for 262 clk.
- Write: wrt with wt_data=16'h0D02 → serf register 0x0D becomes 8'h02, so the serf INT eventually asserts. rd_data[15:8]=8'hA5. SS_n rises while SCLK=1.
- Busy wrt: wrt with 16'h8F00, then wrt with 16'h0D02 at cycle 100 → the first transaction completes unchanged with rd_data[7:0]=8'h6A and no second transfer starts. With SPI_MNRCH_ERR_EN, err=1 from cycle 101 until the next accepted wrt.
- Reset mid-transfer: wrt, then rst at cycle 120 → SS_n=1, SCLK=1, done=0 on the next clk. A fresh wrt of 16'h8F00 then returns 8'h6A.
- Back-to-back: wrt the cycle after done rises, with wt_data=16'hA200 and then 16'hA300 → SS_n high for exactly 1 clk between transfers; both complete with correct pitch-rate bytes from the serf.
